gray_arbiter: RTL and testbench
===============================

// Module: gray_arbiter
// PURPOSE
//  Shares one Gray-code step counter between NREQ requesters. Each requester asks
//  for a burst of Len Gray increments. A round-robin FSM grants the counter to one
//  owner at a time, sequences the steps, pulses per-owner completion and records
//  which owner caused a wrap. Sits between the client blocks and the Gray counter.
// PARAMETERS
//  NREQ   4   number of requesters (2..8)
//  WIDTH  3   Gray counter width in bits
//  LENW   4   burst-length field width per requester
// PORTS
//  Clk        in   1            clock; all state changes on posedge
//  Reset      in   1            asynchronous, active-low reset
//  Req        in   NREQ         request level per requester; held until Done or abort
//  Len        in   NREQ*LENW    burst length, requester i at [i*LENW +: LENW]
//  Clr        in   1            synchronous clear of Count and Wrap
//  Grant      out  NREQ         one-hot; high while owner's burst runs
//  Done       out  NREQ         one-cycle pulse to owner on burst completion
//  Busy       out  1            FSM not in IDLE
//  Count      out  WIDTH        current Gray-coded counter value
//  Wrap       out  1            sticky: counter stepped from max Gray (10..0) to 0
//  WrapOwner  out  $clog2(NREQ) owner of the step that first set Wrap
// BEHAVIOUR
//  - Reset low: every output is 0, FSM=IDLE, RR pointer=0, remaining=0. Takes effect immediately.
//  - FSM states: IDLE, RUN, DONE.
//  - IDLE: if |Req, pick the first requester with Req set, starting at ptr and going upward modulo NREQ.
//    - Latch owner and Len[owner] into rem.
//    - rem!=0 -> RUN with Grant[owner]=1 after this edge.
//    - rem==0 -> DONE; Grant stays 0 and no step occurs.
//  - RUN: every cycle step Count by one Gray increment, rem<=rem-1.
//    - Step taken with rem==1 -> DONE.
//    - Result: exactly Len steps, Count changing on edges 2..Len+1 after the Req sample edge.
//  - Abort in RUN: if Req[owner]==0 at a clock edge, take no step, go to IDLE, drop Grant, no Done.
//  - DONE: Grant=0, Done[owner]=1 for this cycle only; ptr<=owner+1 (mod NREQ); next state IDLE.
//    - After an abort, ptr also advances to owner+1.
//  - Turnaround: at least one IDLE cycle between bursts; back-to-back requesters are served in RR order.
//  - Step arithmetic: Count = bin2gray(bin+1), with the binary count kept internally; wraps 2^WIDTH-1 -> 0.
//  - Wrap: set on the step from gray(2^WIDTH-1) to 0; WrapOwner is captured only when Wrap goes 0->1.
//  - Clr: forces bin/Count=0, Wrap=0, WrapOwner=0.
//    - Clr wins over a step in the same cycle, but rem still decrements.
//    - FSM, Grant and Done are unaffected.
//  - Len is sampled only in IDLE; changes during RUN are ignored.
//  - Req of non-owners is ignored until IDLE.
//  - Busy = (state!=IDLE).
// STRUCTURE
//  - Shared package gray_pkg:
//    - state encoding localparams: ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2;
//    - bin2gray function;
//    - default WIDTH.
//  - One sub-module gray_core (WIDTH): Clk, Reset, Clr, Step -> Count, WrapPulse.
//    - Binary register plus Gray output.
//    - WrapPulse is high on the cycle of a max->0 step.
//  - Top module holds: RR pointer, arbitration (rotate-priority encoder), FSM, rem counter, Wrap/WrapOwner regs.
// TESTING
//  1 Reset, Req=4'b0010, Len1=3 -> Grant=0010 for 3 cycles; Count 000->001->011->010;
//    Done[1] pulses 1 cycle; Busy high 4 cycles.
//  2 Req=4'b1111, all Len=1, ptr=0 -> grants in order 0,1,2,3, each 1 step with 1 IDLE gap;
//    Count ends 110; then ptr=0.
//  3 Req2 with Len=9 from Count=000 (WIDTH=3) -> 8th step 100->000 sets Wrap=1, WrapOwner=2;
//    9th step gives Count=001; Wrap stays 1.
//  4 Req0 Len=5, drop Req0 after 2 steps -> Count=011 holds; Grant drops next edge; no Done[0];
//    pending Req1 granted after 1 IDLE.
//  5 Clr asserted during step 2 of a 4-step burst -> Count=000, Wrap=0;
//    burst completes with 2 more steps (Count=011), Done fires on schedule.
//  6 Req3 with Len=0 -> no Grant, Count unchanged, Done[3] pulses the cycle after the sample;
//    Reset pulled low mid-RUN -> all outputs 0 immediately.

Source files
------------

// File: rtl/gray_pkg.sv
// ------------------------------------------------------------------
// gray_pkg : shared FSM encoding and Gray helpers for gray_arbiter
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package gray_pkg;

  localparam int GRAY_WIDTH = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/gray_core.sv
// ------------------------------------------------------------------
// gray_core : binary step register with Gray-coded view and wrap pulse
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module gray_core
  import gray_pkg::*;
#(
  parameter int WIDTH = GRAY_WIDTH
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Clr,
  input  logic             Step,
  output logic [WIDTH-1:0] Count,
  output logic             WrapPulse
);

  logic [WIDTH-1:0] r_bin;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_bin <= '0;
    end else if (Clr) begin
      r_bin <= '0;
    end else if (Step) begin
      r_bin <= r_bin + 1'b1;
    end
  end

  assign Count = WIDTH'(bin2gray(32'(r_bin)));

  // A cleared step never happens, so it cannot wrap either.
  assign WrapPulse = Step && !Clr && (r_bin == '1);

endmodule

`default_nettype wire

// File: rtl/gray_arbiter.sv
// ------------------------------------------------------------------
// gray_arbiter : round-robin owner of a shared Gray step counter
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module gray_arbiter
  import gray_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = GRAY_WIDTH,
  parameter int LENW  = 4
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic [NREQ-1:0]         Req,
  input  logic [NREQ*LENW-1:0]    Len,
  input  logic                    Clr,
  output logic [NREQ-1:0]         Grant,
  output logic [NREQ-1:0]         Done,
  output logic                    Busy,
  output logic [WIDTH-1:0]        Count,
  output logic                    Wrap,
  output logic [$clog2(NREQ)-1:0] WrapOwner
);

  localparam int PW = $clog2(NREQ);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [PW-1:0]   r_ptr;
  logic [PW-1:0]   r_owner;
  logic [PW-1:0]   r_wrap_owner;
  logic [PW-1:0]   w_pick;
  logic [PW-1:0]   w_owner_inc;
  logic [LENW-1:0] r_rem;
  logic [LENW-1:0] w_pick_len;
  logic            w_found;
  logic            w_step;
  logic            w_owner_req;
  logic            w_wrap_pulse;
  logic            r_wrap;

  // Rotate-priority search: first set request at or above r_ptr, modulo NREQ.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!w_found && Req[(int'(r_ptr) + k) % NREQ]) begin
        w_found = 1'b1;
        w_pick  = PW'((int'(r_ptr) + k) % NREQ);
      end
    end
  end

  assign w_pick_len  = Len[int'(w_pick)*LENW +: LENW];
  assign w_owner_req = Req[r_owner];
  assign w_owner_inc = (r_owner == PW'(NREQ - 1)) ? '0 : r_owner + 1'b1;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_step      = 1'b0;
    Grant       = '0;
    Done        = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_state_nxt = (w_pick_len != '0) ? ST_RUN : ST_DONE;
        end
      end
      ST_RUN: begin
        Grant[r_owner] = 1'b1;
        // Owner dropping its request aborts before any further step.
        if (!w_owner_req) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_step = 1'b1;
          if (r_rem == LENW'(1)) begin
            w_state_nxt = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        Done[r_owner] = 1'b1;
        w_state_nxt   = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_owner      <= '0;
      r_rem        <= '0;
      r_ptr        <= '0;
      r_wrap       <= 1'b0;
      r_wrap_owner <= '0;
    end else begin
      if (r_state == ST_IDLE && w_found) begin
        r_owner <= w_pick;
        r_rem   <= w_pick_len;
      end
      if (w_step) begin
        r_rem <= r_rem - 1'b1;
      end
      if ((r_state == ST_RUN && !w_owner_req) || r_state == ST_DONE) begin
        r_ptr <= w_owner_inc;
      end
      if (Clr) begin
        r_wrap       <= 1'b0;
        r_wrap_owner <= '0;
      end else if (w_wrap_pulse && !r_wrap) begin
        r_wrap       <= 1'b1;
        r_wrap_owner <= r_owner;
      end
    end
  end

  gray_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .Clk       (Clk),
    .Reset     (Reset),
    .Clr       (Clr),
    .Step      (w_step),
    .Count     (Count),
    .WrapPulse (w_wrap_pulse)
  );

  assign Busy      = (r_state != ST_IDLE);
  assign Wrap      = r_wrap;
  assign WrapOwner = r_wrap_owner;

endmodule

`default_nettype wire

// File: tb/tb_gray_arbiter.sv
// ------------------------------------------------------------------
// tb_gray_arbiter : scoreboard bench for gray_arbiter
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_gray_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 3;
  localparam int LENW  = 4;
  localparam int PW    = 2;

  logic                 Clk = 1'b0;
  logic                 Reset;
  logic                 Clr;
  logic [NREQ-1:0]      Req;
  logic [NREQ*LENW-1:0] Len;
  logic [NREQ-1:0]      Grant;
  logic [NREQ-1:0]      Done;
  logic                 Busy;
  logic [WIDTH-1:0]     Count;
  logic                 Wrap;
  logic [PW-1:0]        WrapOwner;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int owner;
    int cnt;
    int wrap;
    int wo;
  } exp_t;

  exp_t sb[$];
  exp_t e_mon;

  // Reference state: binary count as an integer, RR pointer, sticky wrap.
  int m_ptr, m_bin, m_wrap, m_wo;

  logic [NREQ-1:0] rmask;
  int rlen[NREQ];
  int ev_kind;  // 0 none, 1 abort after ev_step steps, 2 clear on step ev_step
  int ev_who;
  int ev_step;

  gray_arbiter #(
    .NREQ  (NREQ),
    .WIDTH (WIDTH),
    .LENW  (LENW)
  ) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Req       (Req),
    .Len       (Len),
    .Clr       (Clr),
    .Grant     (Grant),
    .Done      (Done),
    .Busy      (Busy),
    .Count     (Count),
    .Wrap      (Wrap),
    .WrapOwner (WrapOwner)
  );

  always #5 Clk = ~Clk;

  function automatic int g(input int b);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: consumes one expectation per Done pulse.
  initial begin
    forever begin
      @(negedge Clk);
      if (Reset === 1'b1) begin
        chk("busy_vs_activity", int'(Busy), int'(Grant != 0 || Done != 0));
        chk("grant_onehot0", int'($countones(Grant) <= 1), 1);
        if (Done != 0) begin
          if (sb.size() == 0) begin
            chk("unexpected_done", int'(Done), 0);
          end else begin
            e_mon = sb.pop_front();
            chk("done_owner", int'(Done), 1 << e_mon.owner);
            chk("done_count", int'(Count), g(e_mon.cnt));
            chk("done_wrap", int'(Wrap), e_mon.wrap);
            chk("done_wrapowner", int'(WrapOwner), e_mon.wo);
          end
        end
      end
    end
  end

  // Served order within one round is the requested set walked upward from ptr.
  task automatic model_round();
    int last;
    last = -1;
    for (int k = 0; k < NREQ; k++) begin
      int i;
      int n;
      i = (m_ptr + k) % NREQ;
      if (rmask[i]) begin
        n = (ev_kind == 1 && ev_who == i) ? ev_step : rlen[i];
        for (int t = 1; t <= n; t++) begin
          if (ev_kind == 2 && ev_who == i && ev_step == t) begin
            m_bin = 0; m_wrap = 0; m_wo = 0;
          end else begin
            m_bin = (m_bin + 1) % (1 << WIDTH);
            if (m_bin == 0 && m_wrap == 0) begin
              m_wrap = 1; m_wo = i;
            end
          end
        end
        if (!(ev_kind == 1 && ev_who == i)) sb.push_back('{i, m_bin, m_wrap, m_wo});
        last = i;
      end
    end
    m_ptr = (last + 1) % NREQ;
  endtask

  task automatic run_round();
    int cyc;
    int gcnt;
    cyc  = 0;
    gcnt = 0;
    model_round();
    @(negedge Clk);
    for (int i = 0; i < NREQ; i++) Len[i*LENW +: LENW] = LENW'(rlen[i]);
    Req = rmask;
    while (1) begin
      @(negedge Clk);
      cyc++;
      Clr = 1'b0;
      if (Grant[ev_who]) gcnt++;
      if (ev_kind == 2 && Grant[ev_who] && gcnt == ev_step) Clr = 1'b1;
      if (ev_kind == 1 && Grant[ev_who] && gcnt == ev_step + 1) Req[ev_who] = 1'b0;
      Req = Req & ~Done;
      if (Req == 0 && !Busy) break;
      if (cyc > 500) begin
        chk("round_timeout", cyc, 0);
        break;
      end
    end
    Clr = 1'b0;
    Req = '0;
    chk("queue_drained", sb.size(), 0);
    sb.delete();
    chk("idle_count", int'(Count), g(m_bin));
    chk("idle_wrap", int'(Wrap), m_wrap);
    chk("idle_wrapowner", int'(WrapOwner), m_wo);
  endtask

  task automatic set_round(input logic [NREQ-1:0] mask, input int l0, input int l1,
                           input int l2, input int l3, input int kind, input int who,
                           input int step);
    rmask = mask;
    rlen[0] = l0; rlen[1] = l1; rlen[2] = l2; rlen[3] = l3;
    ev_kind = kind; ev_who = who; ev_step = step;
  endtask

  task automatic do_clr();
    @(negedge Clk);
    Clr = 1'b1;
    @(negedge Clk);
    Clr = 1'b0;
    m_bin = 0; m_wrap = 0; m_wo = 0;
  endtask

  task automatic random_round();
    int off;
    rmask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
    for (int i = 0; i < NREQ; i++) rlen[i] = $urandom_range(0, 10);
    ev_kind = $urandom_range(0, 2);
    ev_who  = -1;
    off     = $urandom_range(0, NREQ - 1);
    for (int k = 0; k < NREQ; k++) begin
      int i;
      i = (off + k) % NREQ;
      if (ev_who < 0 && rmask[i] && rlen[i] >= ((ev_kind == 1) ? 2 : 1)) ev_who = i;
    end
    if (ev_kind == 0 || ev_who < 0) begin
      ev_kind = 0; ev_who = 0; ev_step = 0;
    end else if (ev_kind == 1) begin
      ev_step = $urandom_range(1, rlen[ev_who] - 1);
    end else begin
      ev_step = $urandom_range(1, rlen[ev_who]);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_grant"}, int'(Grant), 0);
    chk({tag, "_done"}, int'(Done), 0);
    chk({tag, "_busy"}, int'(Busy), 0);
    chk({tag, "_count"}, int'(Count), 0);
    chk({tag, "_wrap"}, int'(Wrap), 0);
    chk({tag, "_wrapowner"}, int'(WrapOwner), 0);
  endtask

  initial begin
    int seen;
    Reset = 1'b0; Clr = 1'b0; Req = '0; Len = '0;
    m_ptr = 0; m_bin = 0; m_wrap = 0; m_wo = 0;
    ev_kind = 0; ev_who = 0; ev_step = 0;
    repeat (2) @(negedge Clk);
    check_all_zero("reset");
    Reset = 1'b1;

    set_round(4'b0010, 0, 3, 0, 0, 0, 0, 0); run_round();   // single burst
    set_round(4'b1111, 1, 1, 1, 1, 0, 0, 0); run_round();   // RR over all
    do_clr();
    set_round(4'b0100, 0, 0, 9, 0, 0, 0, 0); run_round();   // wrap by owner 2
    set_round(4'b0011, 5, 2, 0, 0, 1, 0, 2); run_round();   // abort owner 0
    set_round(4'b0001, 4, 0, 0, 0, 2, 0, 2); run_round();   // clear mid-burst
    set_round(4'b1000, 0, 0, 0, 0, 0, 0, 0); run_round();   // zero-length burst

    for (int r = 0; r < 40; r++) begin
      if ($urandom_range(0, 7) == 0) do_clr();
      random_round();
      run_round();
    end

    // Asynchronous reset in the middle of a burst.
    @(negedge Clk);
    Len = '0;
    Len[2*LENW +: LENW] = LENW'(8);
    Req = 4'b0100;
    seen = 0;
    for (int c = 0; c < 20 && seen < 3; c++) begin
      @(negedge Clk);
      if (Grant[2]) seen++;
    end
    chk("midrun_granted", seen, 3);
    #2;
    Reset = 1'b0;
    #1;
    check_all_zero("midrun_reset");
    Req = '0;
    @(negedge Clk);
    Reset = 1'b1;
    m_ptr = 0; m_bin = 0; m_wrap = 0; m_wo = 0;

    set_round(4'b1111, 2, 0, 3, 1, 0, 0, 0); run_round();   // pointer restarts at 0

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
